com_rx_fifo: RTL and testbench
==============================

// Module: com_rx_fifo
// PURPOSE
//  Receive-side byte FIFO between the UART async_receiver (rxdReady/rxdData)
//  and serial_ctrl. Absorbs bursts the CPU cannot drain at 9600 baud, keeps
//  arrival order, flags overrun and raises the COM interrupt (int[2]).
//  First-word-fall-through: head byte is always visible on data_o.
// PARAMETERS
//  DEPTH_LOG2     4   log2 of entry count (DEPTH = 16)
//  INT_THRESHOLD  1   int_o asserts when count >= this (1..DEPTH)
// PORTS
//  clk           in   1   25 MHz system clock (clk25)
//  rst_n         in   1   async reset, active-low
//  rxdReady_i    in   1   1-cycle strobe from async_receiver: push rxdData_i
//  rxdData_i     in   8   received byte
//  pop_i         in   1   serial_ctrl consumes head byte (1-cycle strobe)
//  clearOvr_i    in   1   clears sticky overrun flag
//  data_o        out  8   head byte; 8'h00 when empty
//  empty_o       out  1   count == 0
//  full_o        out  1   count == DEPTH
//  count_o       out  DEPTH_LOG2+1  occupancy 0..DEPTH
//  overrun_o     out  1   sticky: a byte was dropped on full
//  int_o         out  1   registered, count >= INT_THRESHOLD
// BEHAVIOUR
//  - Storage: DEPTH x 8 array, wrPtr/rdPtr DEPTH_LOG2 bits, wrap mod DEPTH;
//    count is a separate DEPTH_LOG2+1 bit register (no ptr-compare tricks).
//  - Reset (rst_n=0, async): wrPtr=rdPtr=0, count=0, overrun=0, int_o=0;
//    hence empty_o=1, full_o=0, data_o=0. Array contents not reset.
//    Reset mid-burst discards all buffered bytes; no partial state survives.
//  - push = rxdReady_i; pop_eff = pop_i & ~empty (pop on empty ignored).
//  - push_eff = push & (~full | pop_eff): full + simultaneous pop -> byte
//    accepted, count unchanged.
//  - Each clk edge: push_eff writes mem[wrPtr], wrPtr++; pop_eff rdPtr++;
//    count += push_eff - pop_eff.
//  - Empty + push + pop: pop ignored, byte stored, count 0->1; data_o shows
//    it the following cycle (latency push->data_o visible = 1 clk).
//  - data_o = empty ? 0 : mem[rdPtr] (combinational read of registered ptr);
//    after pop, next byte appears the cycle after the pop edge.
//  - Overrun: push & full & ~pop_eff -> byte dropped, overrun<=1 (sticky).
//    clearOvr_i clears; if clearOvr_i and a new overrun coincide, overrun=1.
//  - int_o <= (count_next >= INT_THRESHOLD); updates with count, 1 clk after
//    the triggering push/pop; deasserts when drained below threshold.
//  - No state machine beyond pointer/count; all outputs glitch-free from regs
//    except data_o/empty_o/full_o decodes of registered state.
// TESTING
//  1 Reset: rst_n low mid-traffic -> empty_o=1, count_o=0, int_o=0, data_o=0.
//  2 Push 0x41,0x42,0x43 then pop x3 -> data_o 0x41,0x42,0x43 in order,
//    empty_o=1 after third pop, int_o falls 1 clk later.
//  3 Push 16 bytes 0x00..0x0F -> full_o=1, count_o=16; push 0xAA -> dropped,
//    overrun_o=1; pop x16 returns 0x00..0x0F, 0xAA never seen.
//  4 Full + simultaneous push 0x55 and pop -> count_o stays 16, overrun_o=0,
//    0x55 emerges last after 16 pops.
//  5 Empty + simultaneous push 0x7E and pop -> count_o=1, data_o=0x7E.
//  6 Wrap: 40 interleaved push/pop with count 3..5 -> no loss/reorder;
//    clearOvr_i with concurrent overrun -> overrun_o stays 1.

Source files
------------

// File: rtl/com_rx_fifo.sv
// Receive byte FIFO between the UART receiver and serial_ctrl.
// First-word-fall-through, sticky overrun and a registered threshold interrupt.
module com_rx_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int INT_THRESHOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxdReady_i,
    input  logic [7:0]            rxdData_i,
    input  logic                  pop_i,
    input  logic                  clearOvr_i,
    output logic [7:0]            data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overrun_o,
    output logic                  int_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(INT_THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  empty;
    logic                  full;
    logic                  pop_eff;
    logic                  push_eff;
    logic                  ovr_event;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // A pop on a full FIFO frees the slot the coinciding push lands in.
    always_comb begin
        pop_eff    = pop_i & ~empty;
        push_eff   = rxdReady_i & (~full | pop_eff);
        ovr_event  = rxdReady_i & full & ~pop_eff;
        count_next = count;
        unique case ({push_eff, pop_eff})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_o <= 1'b0;
            int_o     <= 1'b0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_eff)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            int_o <= (count_next >= CNT_THR);
            // A new drop wins over a simultaneous clear.
            if (ovr_event)       overrun_o <= 1'b1;
            else if (clearOvr_i) overrun_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr] <= rxdData_i;
    end

    assign data_o  = empty ? 8'h00 : mem[rd_ptr];
    assign empty_o = empty;
    assign full_o  = full;
    assign count_o = count;

endmodule

// File: tb/tb_com_rx_fifo.sv
// Self-checking bench for com_rx_fifo.
// Scoreboard queue holds accepted bytes; heads are compared at each pop.
module tb_com_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxdReady_i = 1'b0;
    logic [7:0] rxdData_i = 8'h00;
    logic       pop_i = 1'b0;
    logic       clearOvr_i = 1'b0;
    logic [7:0] data_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] count_o;
    logic       overrun_o;
    logic       int_o;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [7:0] sb[$];

    com_rx_fifo #(.DEPTH_LOG2(4), .INT_THRESHOLD(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
        .pop_i(pop_i), .clearOvr_i(clearOvr_i),
        .data_o(data_o), .empty_o(empty_o), .full_o(full_o),
        .count_o(count_o), .overrun_o(overrun_o), .int_o(int_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and advance the reference occupancy model.
    task automatic drive(input logic p, input logic [7:0] d,
                         input logic q, input logic c);
        logic pe, acc;
        pe  = q && (exp_cnt > 0);
        acc = p && ((exp_cnt < 16) || pe);
        rxdReady_i = p; rxdData_i = d; pop_i = q; clearOvr_i = c;
        @(posedge clk); #1;
        rxdReady_i = 1'b0; pop_i = 1'b0; clearOvr_i = 1'b0;
        if (pe) void'(sb.pop_front());
        if (acc) sb.push_back(d);
        exp_cnt = exp_cnt + (acc ? 1 : 0) - (pe ? 1 : 0);
    endtask

    task automatic test_reset();
        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (empty_o !== 1'b1 || count_o !== 5'd0 || int_o !== 1'b0 ||
            data_o !== 8'h00 || full_o !== 1'b0 || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: empty=%b cnt=%0d int=%b data=%h full=%b ovr=%b want 1 0 0 00 0 0",
                     empty_o, count_o, int_o, data_o, full_o, overrun_o);
        end
        sb.delete(); exp_cnt = 0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_order();
        drive(1, 8'h41, 0, 0);
        checks++;
        if (data_o !== 8'h41 || int_o !== 1'b1) begin
            errors++;
            $display("FAIL order_latency: data=%h int=%b want 41 1", data_o, int_o);
        end
        drive(1, 8'h42, 0, 0);
        drive(1, 8'h43, 0, 0);
        checks++;
        if (count_o !== 5'd3) begin
            errors++;
            $display("FAIL order_count: got %0d want 3", count_o);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_o !== sb[0]) begin
                errors++;
                $display("FAIL order_pop%0d: got %h want %h", i, data_o, sb[0]);
            end
            if (i == 2) begin
                checks++;
                if (int_o !== 1'b1) begin
                    errors++;
                    $display("FAIL order_int_before: got %b want 1", int_o);
                end
            end
            drive(0, 8'h00, 1, 0);
        end
        checks++;
        if (empty_o !== 1'b1 || int_o !== 1'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL order_drained: empty=%b int=%b data=%h want 1 0 00",
                     empty_o, int_o, data_o);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0);
        checks++;
        if (full_o !== 1'b1 || count_o !== 5'd16 || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL ovr_full: full=%b cnt=%0d ovr=%b want 1 16 0",
                     full_o, count_o, overrun_o);
        end
        drive(1, 8'hAA, 0, 0);
        checks++;
        if (overrun_o !== 1'b1 || count_o !== 5'd16) begin
            errors++;
            $display("FAIL ovr_drop: ovr=%b cnt=%0d want 1 16", overrun_o, count_o);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (data_o !== sb[0] || data_o === 8'hAA) begin
                errors++;
                $display("FAIL ovr_pop%0d: got %h want %h", i, data_o, sb[0]);
            end
            drive(0, 8'h00, 1, 0);
        end
        checks++;
        if (empty_o !== 1'b1 || overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: empty=%b ovr=%b want 1 1", empty_o, overrun_o);
        end
        drive(0, 8'h00, 0, 1);
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: got %b want 0", overrun_o);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] last;
        last = 8'h00;
        for (int i = 0; i < 16; i++) drive(1, 8'(8'h30 + i), 0, 0);
        checks++;
        if (data_o !== 8'h30) begin
            errors++;
            $display("FAIL fpp_head: got %h want 30", data_o);
        end
        drive(1, 8'h55, 1, 0);
        checks++;
        if (count_o !== 5'd16 || overrun_o !== 1'b0 || full_o !== 1'b1) begin
            errors++;
            $display("FAIL fpp_state: cnt=%0d ovr=%b full=%b want 16 0 1",
                     count_o, overrun_o, full_o);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (data_o !== sb[0]) begin
                errors++;
                $display("FAIL fpp_pop%0d: got %h want %h", i, data_o, sb[0]);
            end
            last = data_o;
            drive(0, 8'h00, 1, 0);
        end
        checks++;
        if (last !== 8'h55 || empty_o !== 1'b1) begin
            errors++;
            $display("FAIL fpp_last: got %h empty=%b want 55 1", last, empty_o);
        end
    endtask

    task automatic test_empty_push_pop();
        drive(1, 8'h7E, 1, 0);
        checks++;
        if (count_o !== 5'd1 || data_o !== 8'h7E || empty_o !== 1'b0) begin
            errors++;
            $display("FAIL epp: cnt=%0d data=%h empty=%b want 1 7e 0",
                     count_o, data_o, empty_o);
        end
        drive(0, 8'h00, 1, 0);
        checks++;
        if (empty_o !== 1'b1 || count_o !== 5'd0) begin
            errors++;
            $display("FAIL epp_drain: empty=%b cnt=%0d want 1 0", empty_o, count_o);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] val;
        logic       do_push;
        val = 8'h80;
        for (int i = 0; i < 4; i++) begin
            drive(1, val, 0, 0);
            val++;
        end
        for (int i = 0; i < 40; i++) begin
            if (exp_cnt <= 3)      do_push = 1'b1;
            else if (exp_cnt >= 5) do_push = 1'b0;
            else                   do_push = 1'($urandom_range(0, 1));
            if (do_push) begin
                drive(1, val, 0, 0);
                val++;
            end else begin
                checks++;
                if (data_o !== sb[0]) begin
                    errors++;
                    $display("FAIL wrap_pop%0d: got %h want %h", i, data_o, sb[0]);
                end
                drive(0, 8'h00, 1, 0);
            end
            checks++;
            if (count_o !== 5'(exp_cnt)) begin
                errors++;
                $display("FAIL wrap_cnt%0d: got %0d want %0d", i, count_o, exp_cnt);
            end
        end
        while (exp_cnt > 0) begin
            checks++;
            if (data_o !== sb[0]) begin
                errors++;
                $display("FAIL wrap_drain: got %h want %h", data_o, sb[0]);
            end
            drive(0, 8'h00, 1, 0);
        end
        for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0);
        drive(1, 8'hEE, 0, 0);
        drive(1, 8'hEF, 0, 1);
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_clr_vs_ovr: got %b want 1", overrun_o);
        end
        drive(0, 8'h00, 0, 1);
        checks++;
        if (overrun_o !== 1'b0 || count_o !== 5'd16) begin
            errors++;
            $display("FAIL wrap_clr: ovr=%b cnt=%0d want 0 16", overrun_o, count_o);
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (empty_o !== 1'b1 || count_o !== 5'd0 || data_o !== 8'h00 || int_o !== 1'b0) begin
            errors++;
            $display("FAIL init: empty=%b cnt=%0d data=%h int=%b", empty_o, count_o, data_o, int_o);
        end
        test_reset();
        test_order();
        test_overrun();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
